// File: rtl/ccu_snoop_fanout.sv
// ccu_snoop_fanout
//   Takes one snoop request from the CCU and sends it to every snooped master.
//   It then collects one snoop response from each master and returns their
//   bitwise OR to the CCU. If any master reports DataTransfer, the data burst
//   of the lowest such master goes to the CCU, and the bursts of all other
//   data-carrying masters are drained and discarded.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   ac_valid_i/ac_ready_o         snoop request handshake from the CCU
//   ac_addr_i/ac_snoop_i/ac_prot_i snoop request payload
//   cr_valid_o/cr_ready_i         merged response handshake, cr_resp_o payload
//   cd_valid_o/cd_ready_i         forwarded data handshake, cd_data_o/cd_last_o
//   mst_ac_*                      per-master request valid/ready, shared payload
//   mst_cr_*                      per-master response valid/ready/resp (5 bits each)
//   mst_cd_*                      per-master data valid/ready/data/last
module ccu_snoop_fanout #(
    parameter int NoMstPorts = 4,
    parameter int AddrWidth  = 64,
    parameter int DataWidth  = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ac_valid_i,
    output logic                            ac_ready_o,
    input  logic [AddrWidth-1:0]            ac_addr_i,
    input  logic [3:0]                      ac_snoop_i,
    input  logic [2:0]                      ac_prot_i,
    output logic                            cr_valid_o,
    input  logic                            cr_ready_i,
    output logic [4:0]                      cr_resp_o,
    output logic                            cd_valid_o,
    input  logic                            cd_ready_i,
    output logic [DataWidth-1:0]            cd_data_o,
    output logic                            cd_last_o,
    output logic [NoMstPorts-1:0]           mst_ac_valid_o,
    input  logic [NoMstPorts-1:0]           mst_ac_ready_i,
    output logic [AddrWidth-1:0]            mst_ac_addr_o,
    output logic [3:0]                      mst_ac_snoop_o,
    output logic [2:0]                      mst_ac_prot_o,
    input  logic [NoMstPorts-1:0]           mst_cr_valid_i,
    output logic [NoMstPorts-1:0]           mst_cr_ready_o,
    input  logic [5*NoMstPorts-1:0]         mst_cr_resp_i,
    input  logic [NoMstPorts-1:0]           mst_cd_valid_i,
    output logic [NoMstPorts-1:0]           mst_cd_ready_o,
    input  logic [DataWidth*NoMstPorts-1:0] mst_cd_data_i,
    input  logic [NoMstPorts-1:0]           mst_cd_last_i
);

    localparam int SelW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

    typedef enum logic [2:0] {
        IDLE,
        AC_BCAST,
        CR_COLLECT,
        CR_OUT,
        CD_FWD
    } state_t;

    state_t                  state_q, state_d;
    logic [NoMstPorts-1:0]   ac_pend_q, ac_pend_d;
    logic [NoMstPorts-1:0]   cr_got_q, cr_got_d;
    logic [NoMstPorts-1:0]   cd_done_q, cd_done_d;
    logic [4:0]              resp_q [NoMstPorts];
    logic [AddrWidth-1:0]    addr_q;
    logic [3:0]              snoop_q;
    logic [2:0]              prot_q;

    logic                    ac_hs;
    logic [NoMstPorts-1:0]   cr_take;
    logic [NoMstPorts-1:0]   dmask;
    logic [SelW-1:0]         sel;
    logic [4:0]              resp_or;

    assign mst_ac_addr_o  = addr_q;
    assign mst_ac_snoop_o = snoop_q;
    assign mst_ac_prot_o  = prot_q;

    // Decode of the stored responses. Scanning from the top down leaves sel at
    // the lowest port that carries data.
    always_comb begin
        dmask   = '0;
        sel     = '0;
        resp_or = '0;
        for (int i = NoMstPorts - 1; i >= 0; i--) begin
            resp_or  = resp_or | resp_q[i];
            dmask[i] = resp_q[i][0];
            if (resp_q[i][0]) begin
                sel = SelW'(i);
            end
        end
    end

    // NOTE: every output and next-state variable gets a default value first.
    // This way no path through the case statement can leave one unassigned
    // and infer a latch.
    always_comb begin
        state_d        = state_q;
        ac_pend_d      = ac_pend_q;
        cr_got_d       = cr_got_q;
        cd_done_d      = cd_done_q;
        ac_hs          = 1'b0;
        cr_take        = '0;
        ac_ready_o     = 1'b0;
        cr_valid_o     = 1'b0;
        cr_resp_o      = '0;
        cd_valid_o     = 1'b0;
        cd_data_o      = '0;
        cd_last_o      = 1'b0;
        mst_ac_valid_o = '0;
        mst_cr_ready_o = '0;
        mst_cd_ready_o = '0;

        unique case (state_q)
            IDLE: begin
                // While reset is held the state is already IDLE. Gating with
                // rst_i keeps the request port closed until reset is released.
                ac_ready_o = ~rst_i;
                if (ac_valid_i && !rst_i) begin
                    ac_hs     = 1'b1;
                    ac_pend_d = '1;
                    cr_got_d  = '0;
                    cd_done_d = '0;
                    state_d   = AC_BCAST;
                end
            end

            AC_BCAST: begin
                mst_ac_valid_o = ac_pend_q;
                ac_pend_d      = ac_pend_q & ~mst_ac_ready_i;
                if (ac_pend_d == '0) begin
                    state_d = CR_COLLECT;
                end
            end

            CR_COLLECT: begin
                mst_cr_ready_o = ~cr_got_q;
                cr_take        = mst_cr_valid_i & ~cr_got_q;
                cr_got_d       = cr_got_q | cr_take;
                if (&cr_got_d) begin
                    state_d = CR_OUT;
                end
            end

            CR_OUT: begin
                cr_valid_o = 1'b1;
                cr_resp_o  = resp_or;
                if (cr_ready_i) begin
                    state_d = (dmask != '0) ? CD_FWD : IDLE;
                end
            end

            CD_FWD: begin
                for (int i = 0; i < NoMstPorts; i++) begin
                    if (SelW'(i) == sel) begin
                        // The selected port is coupled to the CCU data channel
                        // until its last beat has been handshaken.
                        cd_valid_o = mst_cd_valid_i[i] & ~cd_done_q[i];
                        cd_last_o  = mst_cd_last_i[i] & ~cd_done_q[i];
                        cd_data_o  = mst_cd_data_i[i*DataWidth +: DataWidth];
                        if (dmask[i] && !cd_done_q[i]) begin
                            mst_cd_ready_o[i] = cd_ready_i;
                        end
                    end else if (dmask[i] && !cd_done_q[i]) begin
                        // The other data-carrying ports are drained: their
                        // beats are accepted and discarded.
                        mst_cd_ready_o[i] = 1'b1;
                    end
                end
                cd_done_d = cd_done_q | (mst_cd_valid_i & mst_cd_ready_o & mst_cd_last_i);
                if ((cd_done_d & dmask) == dmask) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the edge, whatever the order of the statements.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ac_pend_q <= '0;
            cr_got_q  <= '0;
            cd_done_q <= '0;
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            // NOTE: the response store is reset, not left as bare storage.
            // dmask and sel are decoded from it, so stale contents after an
            // aborted transaction would otherwise leak into control.
            for (int i = 0; i < NoMstPorts; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ac_pend_q <= ac_pend_d;
            cr_got_q  <= cr_got_d;
            cd_done_q <= cd_done_d;
            if (ac_hs) begin
                addr_q  <= ac_addr_i;
                snoop_q <= ac_snoop_i;
                prot_q  <= ac_prot_i;
            end
            for (int i = 0; i < NoMstPorts; i++) begin
                if (cr_take[i]) begin
                    resp_q[i] <= mst_cr_resp_i[5*i +: 5];
                end
            end
        end
    end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// tb_ccu_snoop_fanout
//   Directed bench with hand-computed expectations for ccu_snoop_fanout.
//   It uses a 4-port instance for the main scenarios and a 1-port instance
//   for the single-master path. Inputs change and outputs are sampled just
//   after the falling clock edge.
module tb_ccu_snoop_fanout;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-port instance signals
    logic            ac_valid, ac_ready;
    logic [AW-1:0]   ac_addr;
    logic [3:0]      ac_snoop;
    logic [2:0]      ac_prot;
    logic            cr_valid, cr_ready;
    logic [4:0]      cr_resp;
    logic            cd_valid, cd_ready, cd_last;
    logic [DW-1:0]   cd_data;
    logic [N-1:0]    mst_ac_valid, mst_ac_ready;
    logic [AW-1:0]   mst_ac_addr;
    logic [3:0]      mst_ac_snoop;
    logic [2:0]      mst_ac_prot;
    logic [N-1:0]    mst_cr_valid, mst_cr_ready;
    logic [5*N-1:0]  mst_cr_resp;
    logic [N-1:0]    mst_cd_valid, mst_cd_ready, mst_cd_last;
    logic [DW*N-1:0] mst_cd_data;

    // 1-port instance signals
    logic            ac_valid1, ac_ready1;
    logic            cr_valid1, cr_ready1;
    logic [4:0]      cr_resp1;
    logic            cd_valid1, cd_ready1, cd_last1;
    logic [DW-1:0]   cd_data1;
    logic [0:0]      mst_ac_valid1, mst_ac_ready1;
    logic [AW-1:0]   mst_ac_addr1;
    logic [3:0]      mst_ac_snoop1;
    logic [2:0]      mst_ac_prot1;
    logic [0:0]      mst_cr_valid1, mst_cr_ready1;
    logic [4:0]      mst_cr_resp1;
    logic [0:0]      mst_cd_valid1, mst_cd_ready1, mst_cd_last1;
    logic [DW-1:0]   mst_cd_data1;

    int n_checks = 0;
    int n_bad    = 0;
    int beats    = 0;

    ccu_snoop_fanout #(.NoMstPorts(N), .AddrWidth(AW), .DataWidth(DW)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ac_valid_i     (ac_valid),
        .ac_ready_o     (ac_ready),
        .ac_addr_i      (ac_addr),
        .ac_snoop_i     (ac_snoop),
        .ac_prot_i      (ac_prot),
        .cr_valid_o     (cr_valid),
        .cr_ready_i     (cr_ready),
        .cr_resp_o      (cr_resp),
        .cd_valid_o     (cd_valid),
        .cd_ready_i     (cd_ready),
        .cd_data_o      (cd_data),
        .cd_last_o      (cd_last),
        .mst_ac_valid_o (mst_ac_valid),
        .mst_ac_ready_i (mst_ac_ready),
        .mst_ac_addr_o  (mst_ac_addr),
        .mst_ac_snoop_o (mst_ac_snoop),
        .mst_ac_prot_o  (mst_ac_prot),
        .mst_cr_valid_i (mst_cr_valid),
        .mst_cr_ready_o (mst_cr_ready),
        .mst_cr_resp_i  (mst_cr_resp),
        .mst_cd_valid_i (mst_cd_valid),
        .mst_cd_ready_o (mst_cd_ready),
        .mst_cd_data_i  (mst_cd_data),
        .mst_cd_last_i  (mst_cd_last)
    );

    ccu_snoop_fanout #(.NoMstPorts(1), .AddrWidth(AW), .DataWidth(DW)) u_dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .ac_valid_i     (ac_valid1),
        .ac_ready_o     (ac_ready1),
        .ac_addr_i      (64'h5A5A),
        .ac_snoop_i     (4'h1),
        .ac_prot_i      (3'h0),
        .cr_valid_o     (cr_valid1),
        .cr_ready_i     (cr_ready1),
        .cr_resp_o      (cr_resp1),
        .cd_valid_o     (cd_valid1),
        .cd_ready_i     (cd_ready1),
        .cd_data_o      (cd_data1),
        .cd_last_o      (cd_last1),
        .mst_ac_valid_o (mst_ac_valid1),
        .mst_ac_ready_i (mst_ac_ready1),
        .mst_ac_addr_o  (mst_ac_addr1),
        .mst_ac_snoop_o (mst_ac_snoop1),
        .mst_ac_prot_o  (mst_ac_prot1),
        .mst_cr_valid_i (mst_cr_valid1),
        .mst_cr_ready_o (mst_cr_ready1),
        .mst_cr_resp_i  (mst_cr_resp1),
        .mst_cd_valid_i (mst_cd_valid1),
        .mst_cd_ready_o (mst_cd_ready1),
        .mst_cd_data_i  (mst_cd_data1),
        .mst_cd_last_i  (mst_cd_last1)
    );

    // Count beats forwarded to the CCU by the 4-port instance.
    always @(posedge clk) begin
        if (cd_valid && cd_ready) beats++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cd(input int p, input logic v, input logic [DW-1:0] d, input logic l);
        mst_cd_valid[p]        = v;
        mst_cd_data[p*DW +: DW] = d;
        mst_cd_last[p]         = l;
    endtask

    initial begin
        ac_valid = 0; ac_addr = '0; ac_snoop = '0; ac_prot = '0;
        cr_ready = 0; cd_ready = 0;
        mst_ac_ready = '0; mst_cr_valid = '0; mst_cr_resp = '0;
        mst_cd_valid = '0; mst_cd_data = '0; mst_cd_last = '0;
        ac_valid1 = 0; cr_ready1 = 0; cd_ready1 = 0;
        mst_ac_ready1 = '0; mst_cr_valid1 = '0; mst_cr_resp1 = '0;
        mst_cd_valid1 = '0; mst_cd_data1 = '0; mst_cd_last1 = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_ac_ready", ac_ready, 0);
        check("rst_cr_valid", cr_valid, 0);
        check("rst_mst_ac_valid", mst_ac_valid, 0);
        check("rst_mst_cr_ready", mst_cr_ready, 0);
        rst = 0;
        #1;
        check("post_rst_ac_ready", ac_ready, 1);

        // Minimum-latency transaction, all responses zero
        ac_valid = 1; ac_addr = 64'hA1; ac_snoop = 4'h3; ac_prot = 3'h2; mst_ac_ready = '1;
        step();
        ac_valid = 0; mst_cr_valid = '1; mst_cr_resp = '0;
        #1;
        check("t1_bcast_valid", mst_ac_valid, 4'hF);
        check("t1_bcast_addr", mst_ac_addr, 64'hA1);
        check("t1_bcast_snoop", mst_ac_snoop, 4'h3);
        check("t1_bcast_prot", mst_ac_prot, 3'h2);
        check("t1_ac_ready_busy", ac_ready, 0);
        check("t1_no_cr_in_bcast", mst_cr_ready, 0);
        step();
        #1;
        check("t1_cr_ready", mst_cr_ready, 4'hF);
        check("t1_ac_valid_off", mst_ac_valid, 0);
        check("t1_cr_valid_early", cr_valid, 0);
        step();
        mst_cr_valid = '0;
        #1;
        check("t1_cr_valid", cr_valid, 1);
        check("t1_cr_resp", cr_resp, 5'b00000);
        cr_ready = 1;
        step();
        cr_ready = 0;
        #1;
        check("t1_back_idle", ac_ready, 1);
        check("t1_cr_valid_off", cr_valid, 0);

        // Staggered AC ready, then merged responses with two data ports
        ac_valid = 1; ac_addr = 64'hA2; mst_ac_ready = 4'b1011;
        step();
        ac_valid = 0; ac_addr = 64'hDEAD;
        #1;
        check("t2_bcast_all", mst_ac_valid, 4'hF);
        check("t2_addr", mst_ac_addr, 64'hA2);
        step();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t2_port2_held", mst_ac_valid, 4'b0100);
            check("t2_addr_stable", mst_ac_addr, 64'hA2);
            step();
        end
        mst_ac_ready = '1;
        #1;
        check("t2_port2_last", mst_ac_valid, 4'b0100);
        step();
        mst_cr_resp = {5'b00101, 5'b00000, 5'b01001, 5'b00000};
        mst_cr_valid = 4'b1010;
        #1;
        check("t2_ac_done", mst_ac_valid, 0);
        check("t2_cr_ready_all", mst_cr_ready, 4'hF);
        step();
        mst_cr_valid = 4'b0101;
        #1;
        check("t2_cr_ready_rest", mst_cr_ready, 4'b0101);
        step();
        mst_cr_valid = '0;
        #1;
        check("t2_cr_valid", cr_valid, 1);
        check("t2_cr_resp", cr_resp, 5'b01101);
        step();
        #1;
        check("t2_cr_held", cr_valid, 1);
        cr_ready = 1;
        step();
        cr_ready = 0;

        // Data forwarding from port 1, draining port 3, with a CCU stall
        set_cd(1, 1, 64'hD0, 0); set_cd(3, 1, 64'hE0, 0); cd_ready = 1;
        #1;
        check("t3_c0_valid", cd_valid, 1);
        check("t3_c0_data", cd_data, 64'hD0);
        check("t3_c0_last", cd_last, 0);
        check("t3_c0_mready", mst_cd_ready, 4'b1010);
        check("t3_c0_cr_off", cr_valid, 0);
        step();
        set_cd(1, 1, 64'hD1, 0); set_cd(3, 1, 64'hE1, 1);
        #1;
        check("t3_c1_data", cd_data, 64'hD1);
        check("t3_c1_mready", mst_cd_ready, 4'b1010);
        step();
        set_cd(1, 1, 64'hD2, 0); set_cd(3, 0, 64'h0, 0); cd_ready = 0;
        #1;
        check("t3_stall0_mready", mst_cd_ready, 4'b0000);
        check("t3_stall0_valid", cd_valid, 1);
        check("t3_stall0_data", cd_data, 64'hD2);
        step();
        #1;
        check("t3_stall1_mready", mst_cd_ready, 4'b0000);
        check("t3_stall1_data", cd_data, 64'hD2);
        step();
        cd_ready = 1;
        #1;
        check("t3_resume_mready", mst_cd_ready, 4'b0010);
        check("t3_resume_data", cd_data, 64'hD2);
        step();
        set_cd(1, 1, 64'hD3, 1);
        #1;
        check("t3_last_data", cd_data, 64'hD3);
        check("t3_last_flag", cd_last, 1);
        step();
        set_cd(1, 0, 64'h0, 0); cd_ready = 0;
        #1;
        check("t3_idle", ac_ready, 1);
        check("t3_cd_valid_off", cd_valid, 0);
        check("t3_mready_off", mst_cd_ready, 0);
        check("t3_beat_count", beats, 4);

        // Reset during response collection, then a fresh transaction
        ac_valid = 1; ac_addr = 64'hA3; mst_ac_ready = '1;
        step();
        ac_valid = 0;
        step();
        mst_cr_resp = {4{5'b00001}};
        mst_cr_valid = 4'b0011;
        step();
        mst_cr_valid = '0;
        #1;
        check("t4_partial", mst_cr_ready, 4'b1100);
        rst = 1;
        #1;
        check("t4_rst_ac_ready", ac_ready, 0);
        check("t4_rst_cr_ready", mst_cr_ready, 0);
        check("t4_rst_ac_valid", mst_ac_valid, 0);
        check("t4_rst_cr_valid", cr_valid, 0);
        check("t4_rst_cd_valid", cd_valid, 0);
        step();
        rst = 0;
        #1;
        check("t4_rel_ac_ready", ac_ready, 1);
        ac_valid = 1; ac_addr = 64'hA4; mst_ac_ready = '0;
        step();
        ac_valid = 0;
        #1;
        check("t4_fresh_bcast", mst_ac_valid, 4'hF);
        check("t4_fresh_addr", mst_ac_addr, 64'hA4);
        mst_ac_ready = '1;
        step();
        #1;
        check("t4_fresh_cr_ready", mst_cr_ready, 4'hF);
        mst_cr_resp = {5'b00000, 5'b00000, 5'b00000, 5'b00010};
        mst_cr_valid = '1;
        step();
        mst_cr_valid = '0;
        #1;
        check("t4_err_valid", cr_valid, 1);
        check("t4_err_resp", cr_resp, 5'b00010);
        cr_ready = 1;
        step();
        cr_ready = 0;
        #1;
        check("t4_err_idle", ac_ready, 1);
        check("t4_err_no_cd", cd_valid, 0);

        // Single-master instance
        ac_valid1 = 1;
        #1;
        check("t5_ac_ready", ac_ready1, 1);
        step();
        ac_valid1 = 0;
        #1;
        check("t5_bcast", mst_ac_valid1, 1);
        check("t5_addr", mst_ac_addr1, 64'h5A5A);
        mst_ac_ready1 = 1;
        step();
        mst_ac_ready1 = 0;
        #1;
        check("t5_cr_ready", mst_cr_ready1, 1);
        mst_cr_valid1 = 1; mst_cr_resp1 = 5'b00001;
        step();
        mst_cr_valid1 = 0;
        #1;
        check("t5_cr_valid", cr_valid1, 1);
        check("t5_cr_resp", cr_resp1, 5'b00001);
        cr_ready1 = 1;
        step();
        cr_ready1 = 0;
        mst_cd_valid1 = 1; mst_cd_data1 = 64'hF0; mst_cd_last1 = 1; cd_ready1 = 1;
        #1;
        check("t5_cd_valid", cd_valid1, 1);
        check("t5_cd_data", cd_data1, 64'hF0);
        check("t5_cd_last", cd_last1, 1);
        check("t5_cd_mready", mst_cd_ready1, 1);
        step();
        mst_cd_valid1 = 0; mst_cd_last1 = 0; cd_ready1 = 0;
        #1;
        check("t5_idle", ac_ready1, 1);
        check("t5_cd_off", cd_valid1, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
